hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the 8-bit, 8-register pipelined core. It drives the enable, flush and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and computes the ALU operand forwarding selects. It resolves four hazard classes:
- load-use hazards, by stalling;
- taken branches, by flushing;
- multi-cycle data-memory accesses, by freezing;
- read-after-write hazards, by forwarding.

It sits beside the datapath and holds no datapath values.

## Interface
- BR_PENALTY, 1: extra cycles the IF/ID register is flushed after the redirect cycle (0–15).
- MEM_TIMEOUT, 64: wait length that sets `mem_timeout` (1–255).

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_reg1, id_reg2  in  3  source registers of the instruction in ID
- id_use1, id_use2  in  1  ID instruction actually reads reg1/reg2
- ex_reg1, ex_reg2  in  3  source registers held in ID/EX
- ex_regD  in  3  destination register held in ID/EX
- ex_writeReg, ex_is_load  in  1  ID/EX instruction writes a register / is a load
- mem_regD  in  3  destination register held in EX/MEM
- mem_writeReg  in  1  EX/MEM instruction writes a register
- wb_regD  in  3  destination register held in MEM/WB (`regD_o`)
- wb_writeReg  in  1  MEM/WB write enable (`writeReg_o`)
- mem_req  in  1  EX/MEM instruction accesses data memory
- mem_ready  in  1  data memory completes this cycle
- branch_taken  in  1  branch in EX redirects the PC this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  register load enables
- ifid_flush, idex_flush  out  1  load a NOP instead of the stage input
- memwb_bubble  out  1  MEM/WB captures `writeReg=0`
- fwdA, fwdB  out  2  forwarding selects: 00 register file, 10 EX/MEM ALU result, 01 MEM/WB result
- state  out  2  current state: RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3
- stall_cycles, flush_events  out  16  saturating performance counters
- mem_timeout  out  1  sticky timeout flag

## Operation
**Control outputs**
- Controls are combinational in the registered state and the current inputs.
- Default controls are all enables 1 and all flush/bubble signals 0.
- `memwait` = `mem_req & ~mem_ready`.
- `loaduse` = `ex_is_load & ex_writeReg & ((id_use1 & id_reg1==ex_regD) | (id_use2 & id_reg2==ex_regD))`.

**RUN** (evaluated in priority order)
1. If `memwait`:
   - pc/ifid/idex/exmem enables are 0; `memwb_bubble`=1.
   - Next state MEM_WAIT.
2. Else if `branch_taken`:
   - `ifid_flush`=`idex_flush`=1.
   - `flush_events`+1.
   - Next state FLUSH with cnt=BR_PENALTY if BR_PENALTY>0, otherwise RUN.
3. Else if `loaduse`:
   - `pc_en`=`ifid_en`=0; `idex_flush`=1.
   - Next state LOAD_STALL.
4. Else: default controls; next state RUN.

**LOAD_STALL**
- Evaluated exactly like RUN. A new `loaduse` cannot occur against the inserted bubble.

**MEM_WAIT**
- While `mem_ready`=0, hold the freeze controls from RUN rule 1.
- On the cycle `mem_ready`=1, apply RUN rules 2–4 in that same cycle, with identical controls and next states.

**FLUSH**
- `ifid_flush`=1.
- `branch_taken` and `loaduse` are ignored.
- If `memwait`: apply the freeze controls from RUN rule 1, stay in FLUSH, and hold cnt.
- Otherwise cnt decrements; when cnt==1 the next state is RUN.

**Forwarding** (computed in every state)
- `fwdA` = 10 if `mem_writeReg & mem_regD==ex_reg1`.
- Else 01 if `wb_writeReg & wb_regD==ex_reg1`.
- Else 00.
- `fwdB` is the same using `ex_reg2`.

**Counters**
- `stall_cycles` +1 on every cycle with `pc_en`=0.
- Both counters saturate at 16'hFFFF.
- A wait counter counts consecutive `memwait` cycles. It clears on any cycle without `memwait` and saturates at 255.
- `mem_timeout` is set when the wait counter reaches MEM_TIMEOUT and stays set until reset. The controller keeps waiting after a timeout.

## Timing
- Reset, on the edge sampled with `reset`=1:
  - state=RUN, cnt=0, counters=0, `mem_timeout`=0, wait counter=0.
- While `reset`=1, outputs are forced:
  - all enables 1, `ifid_flush`=`idex_flush`=`memwb_bubble`=1, `fwdA`=`fwdB`=00.
- Reset asserted mid-stall, mid-wait or mid-flush aborts to RUN on the next edge.
- Latencies:
  - load-use costs exactly 1 bubble cycle;
  - a taken branch costs 1+BR_PENALTY cycles;
  - a memory access with N cycles of `mem_ready`=0 costs N frozen cycles.
- Simultaneous `memwait` and `branch_taken`: memory wins. The branch is re-evaluated on the release cycle, because the EX instruction is held frozen until then.
- Register address 0 has no special handling; it is a normal register.

## Test plan
- Load-use hazard:
  - Stimulus: `ex_is_load`=1, `ex_writeReg`=1, `ex_regD`=3, `id_reg2`=3, `id_use2`=1.
  - Response: one cycle of `pc_en`=0, `idex_flush`=1, state→1, then RUN; `stall_cycles`=1.
  - Same stimulus with `id_use2`=0: no stall.
- Forwarding priority:
  - Stimulus: `ex_reg1`=5, `mem_regD`=5, `wb_regD`=5, both write flags 1 → response `fwdA`=10.
  - Clear `mem_writeReg` → `fwdA`=01.
  - Clear `wb_writeReg` → `fwdA`=00.
- Taken branch, BR_PENALTY=2:
  - Stimulus: pulse `branch_taken`.
  - Response: `ifid_flush`=1 for 3 consecutive cycles, `idex_flush`=1 only in the first, state 3 for 2 cycles; `flush_events`=1.
- Memory wait:
  - Stimulus: `mem_req`=1 with `mem_ready`=0 for 4 cycles, then 1.
  - Response: 4 cycles with pc/ifid/idex/exmem enables 0, `memwb_bubble`=1, state=2; normal controls on the ready cycle.
  - Repeat with `branch_taken`=1 held throughout: the flush occurs only on the ready cycle.
- Timeout:
  - Stimulus: MEM_TIMEOUT=8, `mem_ready` held 0 for 10 cycles.
  - Response: `mem_timeout` rises on the 8th wait cycle and stays 1 after `mem_ready`; it clears only on reset.
- Reset mid-operation:
  - Stimulus: assert `reset` during FLUSH (cnt=2) and during MEM_WAIT.
  - Response: next cycle state=0, counters 0, forced reset outputs observed while `reset`=1.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline hazard control bundle.
// master = datapath side, slave = controller side.
interface hazard_ctrl_if;
  logic [2:0]  id_reg1;
  logic [2:0]  id_reg2;
  logic        id_use1;
  logic        id_use2;
  logic [2:0]  ex_reg1;
  logic [2:0]  ex_reg2;
  logic [2:0]  ex_regD;
  logic        ex_writeReg;
  logic        ex_is_load;
  logic [2:0]  mem_regD;
  logic        mem_writeReg;
  logic [2:0]  wb_regD;
  logic        wb_writeReg;
  logic        mem_req;
  logic        mem_ready;
  logic        branch_taken;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        memwb_bubble;
  logic [1:0]  fwdA;
  logic [1:0]  fwdB;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic [15:0] flush_events;
  logic        mem_timeout;

  modport master (
    output id_reg1, id_reg2, id_use1, id_use2,
    output ex_reg1, ex_reg2, ex_regD,
    output ex_writeReg, ex_is_load,
    output mem_regD, mem_writeReg,
    output wb_regD, wb_writeReg,
    output mem_req, mem_ready, branch_taken,
    input  pc_en, ifid_en, idex_en,
    input  exmem_en, memwb_en,
    input  ifid_flush, idex_flush, memwb_bubble,
    input  fwdA, fwdB, state,
    input  stall_cycles, flush_events, mem_timeout
  );

  modport slave (
    input  id_reg1, id_reg2, id_use1, id_use2,
    input  ex_reg1, ex_reg2, ex_regD,
    input  ex_writeReg, ex_is_load,
    input  mem_regD, mem_writeReg,
    input  wb_regD, wb_writeReg,
    input  mem_req, mem_ready, branch_taken,
    output pc_en, ifid_en, idex_en,
    output exmem_en, memwb_en,
    output ifid_flush, idex_flush, memwb_bubble,
    output fwdA, fwdB, state,
    output stall_cycles, flush_events, mem_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / flush / freeze sequencing and
// ALU operand forwarding for the 8-register pipeline.
module hazard_ctrl #(
  parameter int unsigned BR_PENALTY  = 1,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic    clk,
  input  logic    reset,
  hazard_ctrl_if.slave hz
);

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] LOAD_STALL = 2'd1;
  localparam logic [1:0] MEM_WAIT   = 2'd2;
  localparam logic [1:0] FLUSH      = 2'd3;

  localparam logic [3:0] PEN = 4'(BR_PENALTY);
  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] stall_q, flush_q;
  logic        tmo_q;

  logic memwait, loaduse, freeze;
  logic pc_en_c, ifid_en_c, idex_en_c;
  logic exmem_en_c, memwb_en_c;
  logic ifid_fl_c, idex_fl_c, bubble_c;
  logic flush_inc;
  logic [1:0] fa, fb;

  assign memwait = hz.mem_req & ~hz.mem_ready;

  assign loaduse = hz.ex_is_load & hz.ex_writeReg &
    ((hz.id_use1 & (hz.id_reg1 == hz.ex_regD)) |
     (hz.id_use2 & (hz.id_reg2 == hz.ex_regD)));

  // the EX/MEM access is held frozen, so in MEM_WAIT
  // only the ready strobe releases it
  assign freeze = (state_q == MEM_WAIT) ?
    ~hz.mem_ready : memwait;

  assign wait_d = !memwait ? 8'd0 :
    (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;

  // next-state and pipeline control decode
  always_comb begin
    pc_en_c    = 1'b1;
    ifid_en_c  = 1'b1;
    idex_en_c  = 1'b1;
    exmem_en_c = 1'b1;
    memwb_en_c = 1'b1;
    ifid_fl_c  = 1'b0;
    idex_fl_c  = 1'b0;
    bubble_c   = 1'b0;
    flush_inc  = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (state_q == FLUSH) begin
      ifid_fl_c = 1'b1;
      if (memwait) begin
        pc_en_c    = 1'b0;
        ifid_en_c  = 1'b0;
        idex_en_c  = 1'b0;
        exmem_en_c = 1'b0;
        bubble_c   = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1)
          state_d = RUN;
      end
    end else begin
      unique case (1'b1)
        freeze: begin
          pc_en_c    = 1'b0;
          ifid_en_c  = 1'b0;
          idex_en_c  = 1'b0;
          exmem_en_c = 1'b0;
          bubble_c   = 1'b1;
          state_d    = MEM_WAIT;
        end
        (!freeze && hz.branch_taken): begin
          ifid_fl_c = 1'b1;
          idex_fl_c = 1'b1;
          flush_inc = 1'b1;
          if (PEN != 4'd0) begin
            state_d = FLUSH;
            cnt_d   = PEN;
          end else begin
            state_d = RUN;
          end
        end
        (!freeze && !hz.branch_taken && loaduse): begin
          pc_en_c   = 1'b0;
          ifid_en_c = 1'b0;
          idex_fl_c = 1'b1;
          state_d   = LOAD_STALL;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // operand forwarding, newest producer first
  always_comb begin
    fa = 2'b00;
    fb = 2'b00;
    if (hz.mem_writeReg && hz.mem_regD == hz.ex_reg1)
      fa = 2'b10;
    else if (hz.wb_writeReg && hz.wb_regD == hz.ex_reg1)
      fa = 2'b01;
    if (hz.mem_writeReg && hz.mem_regD == hz.ex_reg2)
      fb = 2'b10;
    else if (hz.wb_writeReg && hz.wb_regD == hz.ex_reg2)
      fb = 2'b01;
  end

  // state, penalty count, perf counters and timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      wait_q  <= 8'd0;
      stall_q <= 16'd0;
      flush_q <= 16'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      if (!pc_en_c && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
      if (flush_inc && flush_q != 16'hFFFF)
        flush_q <= flush_q + 16'd1;
      if (wait_d == TMO)
        tmo_q <= 1'b1;
    end
  end

  assign hz.pc_en        = reset | pc_en_c;
  assign hz.ifid_en      = reset | ifid_en_c;
  assign hz.idex_en      = reset | idex_en_c;
  assign hz.exmem_en     = reset | exmem_en_c;
  assign hz.memwb_en     = reset | memwb_en_c;
  assign hz.ifid_flush   = reset | ifid_fl_c;
  assign hz.idex_flush   = reset | idex_fl_c;
  assign hz.memwb_bubble = reset | bubble_c;
  assign hz.fwdA         = reset ? 2'b00 : fa;
  assign hz.fwdB         = reset ? 2'b00 : fb;
  assign hz.state        = state_q;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_events = flush_q;
  assign hz.mem_timeout  = tmo_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl
// with BR_PENALTY=2, MEM_TIMEOUT=8.
module tb_hazard_ctrl;

  logic clk;
  logic reset;
  hazard_ctrl_if hif ();

  hazard_ctrl #(
    .BR_PENALTY (2),
    .MEM_TIMEOUT(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] NRM = 5'b11111;
  localparam logic [4:0] FRZ = 5'b00001;
  localparam logic [4:0] STL = 5'b00111;

  typedef struct {
    string       tag;
    logic [13:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk;
  int  n_fail;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] mk(
    input logic [4:0] en, input logic [2:0] fl,
    input logic [1:0] fa, input logic [1:0] fb,
    input logic [1:0] st);
    return {en, fl, fa, fb, st};
  endfunction

  function automatic logic [13:0] obs();
    return {hif.pc_en, hif.ifid_en, hif.idex_en,
            hif.exmem_en, hif.memwb_en,
            hif.ifid_flush, hif.idex_flush,
            hif.memwb_bubble,
            hif.fwdA, hif.fwdB, hif.state};
  endfunction

  // one cycle: queue expectation, compare mid-cycle,
  // then advance past the next rising edge
  task automatic cyc(input string tag,
                     input logic [13:0] exp);
    sb_t e;
    sb_q.push_back('{tag, exp});
    @(negedge clk);
    e = sb_q.pop_front();
    check(e.tag, 16'(obs()), 16'(e.exp));
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    hif.id_reg1 = 3'd1; hif.id_reg2 = 3'd2;
    hif.id_use1 = 1'b0; hif.id_use2 = 1'b0;
    hif.ex_reg1 = 3'd1; hif.ex_reg2 = 3'd2;
    hif.ex_regD = 3'd7;
    hif.ex_writeReg = 1'b0; hif.ex_is_load = 1'b0;
    hif.mem_regD = 3'd6; hif.mem_writeReg = 1'b0;
    hif.wb_regD = 3'd5; hif.wb_writeReg = 1'b0;
    hif.mem_req = 1'b0; hif.mem_ready = 1'b1;
    hif.branch_taken = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    quiet();
    reset = 1'b1;
    hif.ex_reg1 = 3'd6;
    hif.mem_writeReg = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst_force", mk(NRM, 3'b111, 2'b00, 2'b00, 2'd0));
    check("rst_stall", hif.stall_cycles, 16'd0);
    check("rst_flush", hif.flush_events, 16'd0);
    check("rst_tmo", 16'(hif.mem_timeout), 16'd0);
    reset = 1'b0;
    quiet();
    cyc("idle", mk(NRM, 3'b000, 2'b00, 2'b00, 2'd0));

    hif.ex_is_load = 1'b1; hif.ex_writeReg = 1'b1;
    hif.ex_regD = 3'd3; hif.id_reg2 = 3'd3;
    hif.id_use2 = 1'b1;
    cyc("lu_stall", mk(STL, 3'b010, 2'b00, 2'b00, 2'd0));
    hif.ex_is_load = 1'b0; hif.ex_writeReg = 1'b0;
    cyc("lu_bubble", mk(NRM, 3'b000, 2'b00, 2'b00, 2'd1));
    cyc("lu_run", mk(NRM, 3'b000, 2'b00, 2'b00, 2'd0));
    check("lu_cnt", hif.stall_cycles, 16'd1);
    hif.ex_is_load = 1'b1; hif.ex_writeReg = 1'b1;
    hif.id_use2 = 1'b0;
    cyc("lu_nouse", mk(NRM, 3'b000, 2'b00, 2'b00, 2'd0));
    check("lu_nouse_cnt", hif.stall_cycles, 16'd1);
    hif.ex_regD = 3'd0; hif.id_reg1 = 3'd0;
    hif.id_use1 = 1'b1;
    cyc("lu_r0", mk(STL, 3'b010, 2'b00, 2'b00, 2'd0));
    quiet();
    cyc("lu_r0_bub", mk(NRM, 3'b000, 2'b00, 2'b00, 2'd1));

    hif.ex_reg1 = 3'd5; hif.ex_reg2 = 3'd2;
    hif.mem_regD = 3'd5; hif.wb_regD = 3'd5;
    hif.mem_writeReg = 1'b1; hif.wb_writeReg = 1'b1;
    cyc("fwd_mem", mk(NRM, 3'b000, 2'b10, 2'b00, 2'd0));
    hif.mem_writeReg = 1'b0; hif.ex_reg2 = 3'd5;
    cyc("fwd_wb", mk(NRM, 3'b000, 2'b01, 2'b01, 2'd0));
    hif.wb_writeReg = 1'b0;
    cyc("fwd_rf", mk(NRM, 3'b000, 2'b00, 2'b00, 2'd0));
    quiet();

    hif.branch_taken = 1'b1;
    cyc("br_0", mk(NRM, 3'b110, 2'b00, 2'b00, 2'd0));
    cyc("br_1", mk(NRM, 3'b100, 2'b00, 2'b00, 2'd3));
    cyc("br_2", mk(NRM, 3'b100, 2'b00, 2'b00, 2'd3));
    hif.branch_taken = 1'b0;
    cyc("br_end", mk(NRM, 3'b000, 2'b00, 2'b00, 2'd0));
    check("br_cnt", hif.flush_events, 16'd1);

    hif.mem_req = 1'b1; hif.mem_ready = 1'b0;
    cyc("mw_0", mk(FRZ, 3'b001, 2'b00, 2'b00, 2'd0));
    for (int i = 1; i < 4; i++)
      cyc("mw_n", mk(FRZ, 3'b001, 2'b00, 2'b00, 2'd2));
    hif.mem_ready = 1'b1;
    cyc("mw_rdy", mk(NRM, 3'b000, 2'b00, 2'b00, 2'd2));
    hif.mem_req = 1'b0;
    cyc("mw_run", mk(NRM, 3'b000, 2'b00, 2'b00, 2'd0));
    check("mw_stall", hif.stall_cycles, 16'd6);
    check("mw_tmo", 16'(hif.mem_timeout), 16'd0);

    hif.mem_req = 1'b1; hif.mem_ready = 1'b0;
    hif.branch_taken = 1'b1;
    cyc("mb_0", mk(FRZ, 3'b001, 2'b00, 2'b00, 2'd0));
    cyc("mb_1", mk(FRZ, 3'b001, 2'b00, 2'b00, 2'd2));
    cyc("mb_2", mk(FRZ, 3'b001, 2'b00, 2'b00, 2'd2));
    hif.mem_ready = 1'b1;
    cyc("mb_rdy", mk(NRM, 3'b110, 2'b00, 2'b00, 2'd2));
    hif.mem_req = 1'b0; hif.branch_taken = 1'b0;
    cyc("mb_f1", mk(NRM, 3'b100, 2'b00, 2'b00, 2'd3));
    cyc("mb_f2", mk(NRM, 3'b100, 2'b00, 2'b00, 2'd3));
    cyc("mb_run", mk(NRM, 3'b000, 2'b00, 2'b00, 2'd0));
    check("mb_flush", hif.flush_events, 16'd2);
    check("mb_stall", hif.stall_cycles, 16'd9);

    hif.mem_req = 1'b1; hif.mem_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 8)
        check("tmo_early", 16'(hif.mem_timeout), 16'd0);
      if (i == 9)
        check("tmo_rise", 16'(hif.mem_timeout), 16'd1);
      cyc("tmo_wait", mk(FRZ, 3'b001, 2'b00, 2'b00,
                         (i == 1) ? 2'd0 : 2'd2));
    end
    hif.mem_ready = 1'b1;
    cyc("tmo_rdy", mk(NRM, 3'b000, 2'b00, 2'b00, 2'd2));
    hif.mem_req = 1'b0;
    cyc("tmo_run", mk(NRM, 3'b000, 2'b00, 2'b00, 2'd0));
    check("tmo_sticky", 16'(hif.mem_timeout), 16'd1);
    check("tmo_stall", hif.stall_cycles, 16'd19);

    hif.branch_taken = 1'b1;
    cyc("fm_br", mk(NRM, 3'b110, 2'b00, 2'b00, 2'd0));
    hif.branch_taken = 1'b0;
    hif.mem_req = 1'b1; hif.mem_ready = 1'b0;
    cyc("fm_frz1", mk(FRZ, 3'b101, 2'b00, 2'b00, 2'd3));
    cyc("fm_frz2", mk(FRZ, 3'b101, 2'b00, 2'b00, 2'd3));
    hif.mem_req = 1'b0; hif.mem_ready = 1'b1;
    cyc("fm_f1", mk(NRM, 3'b100, 2'b00, 2'b00, 2'd3));
    cyc("fm_f2", mk(NRM, 3'b100, 2'b00, 2'b00, 2'd3));
    cyc("fm_run", mk(NRM, 3'b000, 2'b00, 2'b00, 2'd0));
    check("fm_flush", hif.flush_events, 16'd3);
    check("fm_stall", hif.stall_cycles, 16'd21);

    hif.branch_taken = 1'b1;
    cyc("rf_br", mk(NRM, 3'b110, 2'b00, 2'b00, 2'd0));
    hif.branch_taken = 1'b0;
    reset = 1'b1;
    hif.mem_writeReg = 1'b1; hif.mem_regD = 3'd1;
    cyc("rf_force", mk(NRM, 3'b111, 2'b00, 2'b00, 2'd3));
    reset = 1'b0;
    quiet();
    cyc("rf_run", mk(NRM, 3'b000, 2'b00, 2'b00, 2'd0));
    check("rf_stall", hif.stall_cycles, 16'd0);
    check("rf_flush", hif.flush_events, 16'd0);
    check("rf_tmo", 16'(hif.mem_timeout), 16'd0);

    hif.mem_req = 1'b1; hif.mem_ready = 1'b0;
    cyc("rw_0", mk(FRZ, 3'b001, 2'b00, 2'b00, 2'd0));
    reset = 1'b1;
    cyc("rw_force", mk(NRM, 3'b111, 2'b00, 2'b00, 2'd2));
    reset = 1'b0;
    quiet();
    cyc("rw_run", mk(NRM, 3'b000, 2'b00, 2'b00, 2'd0));
    check("rw_stall", hif.stall_cycles, 16'd0);

    check("sb_empty", 16'(sb_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
